z80_bus_responder: RTL
======================

// Module: z80_bus_responder
// PURPOSE
//  Synthesizable memory/IO target for the z80cpu bus: decodes MREQ/IORQ/RD/WR, inserts WAIT states,
//  and forwards reads/writes to a synchronous memory port with fixed latency.
//  Adds a console port: memory writes to CON_ADDR are pushed into a FIFO with a valid/ready output.
//  Also provides a HALT detector and a Z80-clock counter so benches and FPGA tops can use one test harness.
// PARAMETERS
//  WAIT_CYC   2       MCLK cycles WAIT held low after memory access start (0 = no wait states)
//  MEM_LAT    1       MCLK cycles from mem_rd pulse to mem_rdata valid; must be < WAIT_CYC+4
//  CON_ADDR   16'h1234  console write address
//  CON_DEPTH  16      console FIFO depth, power of two
//  CNT_W      32      width of the Z80 clock counter
// PORTS
//  MCLK        in   1      master clock; all state on posedge
//  RESET       in   1      async, active-low
//  ZCLK        in   1      Z80 CLK, sampled on MCLK for counting
//  ADDRESS     in   16     CPU address;  ADDRESS_z in 1: address floating
//  DATA_i      in   8      CPU write data; DATA_z in 1: CPU data floating
//  M1,MREQ,IORQ,RD,WR,RFSH,HALT  in 1  active-low strobes; MREQ_z,IORQ_z,RD_z,WR_z in 1: strobe floating
//  DATA_o      out  8      read data to CPU;  DATA_oe out 1: drive DATA_o
//  WAIT        out  1      active-low wait request
//  mem_addr    out  16     memory address;  mem_rd/mem_wr out 1: one-MCLK pulses
//  mem_wdata   out  8      write data;  mem_rdata in 8: read data, valid MEM_LAT after mem_rd
//  con_data    out  8      FIFO head;  con_valid out 1;  con_ready in 1
//  con_ovf     out  1      sticky: a push was dropped because FIFO was full
//  halted      out  1      sticky HALT seen;  zclocks out CNT_W: count of ZCLK rising edges
// BEHAVIOUR
//  Reset values: DATA_o=8'h00, DATA_oe=0, WAIT=1, mem_rd=mem_wr=0, mem_addr=0, con_valid=0,
//   con_ovf=0, halted=0, zclocks=0; FIFO emptied. Reset mid-access aborts it with no memory write.
//  Strobe valid = low && !_z. mem_act = MREQ valid && RFSH high (refresh ignored); io_act = IORQ valid && !M1 low.
//  Strobes are registered once; start = rising edge of (act && (RD|WR valid)) in the registered copy.
//  FSM: IDLE -> WAITST (WAIT=0, counter=WAIT_CYC) -> DATA -> HOLD -> IDLE.
//   IDLE: on memory read start: mem_rd=1 for 1 cycle, mem_addr=ADDRESS; go WAITST, or DATA if WAIT_CYC=0.
//         on memory write start: require DATA_z=0; mem_wr=1, mem_wdata=DATA_i; if ADDRESS==CON_ADDR push.
//         Write goes WAITST/DATA identically but never asserts DATA_oe.
//         on IO read: DATA_o = ADDRESS[0] ? 8'hFF : 8'hBF, DATA_oe=1, go HOLD (no WAIT). IO write ignored.
//   WAITST: decrement; at 1 release WAIT next cycle, go DATA.
//   DATA: for reads, latch mem_rdata into DATA_o exactly MEM_LAT cycles after mem_rd; DATA_oe=1.
//   HOLD: keep DATA_o/DATA_oe until strobe deasserts (registered), then DATA_oe=0, IDLE.
//  Strobe deasserted early in WAITST/DATA: WAIT=1, DATA_oe=0, IDLE next cycle; a started write is not retracted.
//  Simultaneous read and write strobes: treated as protocol error, ignored (stay IDLE).
//  FIFO: push on console write; pop when con_valid&&con_ready. Full+push+pop same cycle: both happen.
//   Full+push without pop: byte dropped, con_ovf=1 until reset. Pointers wrap modulo CON_DEPTH.
//  halted set on first registered HALT=0 after reset; zclocks +1 on each registered ZCLK 0->1 edge
//   while !halted; saturates at all-ones, never wraps.
// STRUCTURE
//  Package z80_bus_pkg: FSM state enum (IDLE,WAITST,DATA,HOLD), IO_ODD=8'hFF, IO_EVEN=8'hBF,
//   ROM_TOP=16'h4000 for tops splitting the memory port.
//  Sub-module z80_con_fifo (push/pop/full/empty, CON_DEPTH param); remaining logic flat.
// TESTING
//  Read 0x0003 with mem model returning 8'hCD, WAIT_CYC=2 -> WAIT low 2 MCLK, DATA_o=8'hCD, DATA_oe until RD high.
//  Write 8'h41 to 0x1234, con_ready=0 -> one mem_wr, con_valid=1, con_data=8'h41; ready=1 pops, valid=0.
//  17 writes to CON_ADDR, ready=0, depth 16 -> 16 stored in order, con_ovf=1, 17th byte lost.
//  IO read port 0xFE -> 8'hBF; port 0xFF -> 8'hFF; WAIT stays 1; no mem_rd pulse.
//  Refresh cycle (MREQ=0,RFSH=0) and MREQ_z=1 -> no mem_rd/mem_wr, WAIT=1, DATA_oe=0.
//  Run 100 ZCLK edges then HALT=0 -> zclocks=100 frozen, halted=1; RESET in WAITST -> WAIT=1, all reset values.

Source files
------------

// File: rtl/z80_bus_responder_pkg.sv
// Shared types and constants for the Z80 bus responder: FSM states, IO read values
// and the ROM/RAM split point used by tops that divide the memory port.
package z80_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAITST = 2'd1,
      ST_DATA   = 2'd2,
      ST_HOLD   = 2'd3
   } bus_state_t;

   localparam logic [7:0]  IO_ODD  = 8'hFF;
   localparam logic [7:0]  IO_EVEN = 8'hBF;
   localparam logic [15:0] ROM_TOP = 16'h4000;

   function automatic logic [7:0] io_read_data(input logic addr_lsb);
      return addr_lsb ? IO_ODD : IO_EVEN;
   endfunction

endpackage

// File: rtl/z80_bus_responder_if.sv
// Z80 CPU bus plus the responder's memory and console ports; the responder sits on
// the slave modport, the CPU/memory/console side on the master modport.
interface z80_bus_responder_if #(
   parameter int CNT_W = 32
);
   logic             zclk;
   logic [15:0]      address;
   logic             address_z;
   logic [7:0]       data_i;
   logic             data_z;
   logic             m1;
   logic             mreq;
   logic             iorq;
   logic             rd;
   logic             wr;
   logic             rfsh;
   logic             halt;
   logic             mreq_z;
   logic             iorq_z;
   logic             rd_z;
   logic             wr_z;
   logic [7:0]       data_o;
   logic             data_oe;
   logic             wait_n;
   logic [15:0]      mem_addr;
   logic             mem_rd;
   logic             mem_wr;
   logic [7:0]       mem_wdata;
   logic [7:0]       mem_rdata;
   logic [7:0]       con_data;
   logic             con_valid;
   logic             con_ready;
   logic             con_ovf;
   logic             halted;
   logic [CNT_W-1:0] zclocks;

   modport slave (
      input  zclk, address, address_z, data_i, data_z, m1, mreq, iorq, rd, wr, rfsh, halt,
             mreq_z, iorq_z, rd_z, wr_z, mem_rdata, con_ready,
      output data_o, data_oe, wait_n, mem_addr, mem_rd, mem_wr, mem_wdata,
             con_data, con_valid, con_ovf, halted, zclocks
   );

   modport master (
      output zclk, address, address_z, data_i, data_z, m1, mreq, iorq, rd, wr, rfsh, halt,
             mreq_z, iorq_z, rd_z, wr_z, mem_rdata, con_ready,
      input  data_o, data_oe, wait_n, mem_addr, mem_rd, mem_wr, mem_wdata,
             con_data, con_valid, con_ovf, halted, zclocks
   );
endinterface

// File: rtl/z80_bus_responder_con_fifo.sv
// Console byte FIFO: head visible combinationally, pop gated by empty, push gated by full
// unless a pop frees the slot on the same edge.
module z80_con_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] store [DEPTH];
   logic [AW:0]  wr_ptr_q;
   logic [AW:0]  rd_ptr_q;
   logic         do_push;
   logic         do_pop;

   // Extra pointer bit separates full from empty when the indices coincide.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = store[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) store[wr_ptr_q[AW-1:0]] <= push_dat;
   end
endmodule

// File: rtl/z80_bus_responder.sv
// Z80 memory/IO target: registers strobes once, issues one-cycle mem_rd/mem_wr pulses with
// WAIT_CYC wait states, returns read data MEM_LAT cycles after mem_rd; console FIFO drops on full.
module z80_bus_responder
   import z80_bus_pkg::*;
#(
   parameter int          WAIT_CYC  = 2,
   parameter int          MEM_LAT   = 1,
   parameter logic [15:0] CON_ADDR  = 16'h1234,
   parameter int          CON_DEPTH = 16,
   parameter int          CNT_W     = 32
) (
   input logic                mclk,
   input logic                rst_n,
   z80_bus_responder_if.slave bus
);
   localparam int WCW = $clog2(WAIT_CYC + 2);

   bus_state_t       state_q, state_d;
   logic             mem_act_q, io_act_q, rd_q, wr_q, mem_prev_q, io_prev_q;
   logic             halt_q, zclk_q, zclk_qq;
   logic             mem_req, io_req, mem_start, io_start, one_dir;
   logic             do_mem_rd, do_mem_wr, do_io_rd, set_oe, clr_oe;
   logic             mem_rd_q, mem_wr_q, data_oe_q, acc_rd_q, acc_io_q, got_q;
   logic [15:0]      mem_addr_q;
   logic [7:0]       mem_wdata_q, data_o_q;
   logic [WCW-1:0]   wcnt_q;
   logic             rdata_vld, capture;
   logic             con_push, fifo_full, fifo_empty, con_ovf_q;
   logic             halted_q;
   logic [CNT_W-1:0] zclocks_q;

   wire mreq_v = !bus.mreq && !bus.mreq_z;
   wire iorq_v = !bus.iorq && !bus.iorq_z;
   wire rd_v   = !bus.rd && !bus.rd_z;
   wire wr_v   = !bus.wr && !bus.wr_z;

   // Single register stage on the asynchronous CPU strobes; all decisions use this copy.
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         mem_act_q  <= 1'b0;
         io_act_q   <= 1'b0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         mem_prev_q <= 1'b0;
         io_prev_q  <= 1'b0;
         halt_q     <= 1'b0;
         zclk_q     <= 1'b0;
         zclk_qq    <= 1'b0;
      end else begin
         mem_act_q  <= mreq_v && bus.rfsh;
         io_act_q   <= iorq_v && bus.m1;
         rd_q       <= rd_v;
         wr_q       <= wr_v;
         mem_prev_q <= mem_req;
         io_prev_q  <= io_req;
         halt_q     <= !bus.halt;
         zclk_q     <= bus.zclk;
         zclk_qq    <= zclk_q;
      end
   end

   assign mem_req   = mem_act_q && (rd_q || wr_q);
   assign io_req    = io_act_q && (rd_q || wr_q);
   assign mem_start = mem_req && !mem_prev_q;
   assign io_start  = io_req && !io_prev_q;
   assign one_dir   = rd_q ^ wr_q;

   generate
      if (MEM_LAT == 0) begin : g_lat0
         assign rdata_vld = mem_rd_q;
      end else begin : g_latn
         logic [MEM_LAT-1:0] rd_pipe_q;
         always_ff @(posedge mclk or negedge rst_n) begin
            if (!rst_n) begin
               rd_pipe_q <= '0;
            end else begin
               rd_pipe_q[0] <= mem_rd_q;
               for (int i = 1; i < MEM_LAT; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
            end
         end
         assign rdata_vld = rd_pipe_q[MEM_LAT-1];
      end
   endgenerate

   assign capture = acc_rd_q && rdata_vld && !got_q &&
                    ((state_q == ST_WAITST) || (state_q == ST_DATA));

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      do_mem_rd = 1'b0;
      do_mem_wr = 1'b0;
      do_io_rd  = 1'b0;
      set_oe    = 1'b0;
      clr_oe    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_start && one_dir && !bus.address_z) begin
               do_mem_rd = rd_q;
               do_mem_wr = wr_q && !bus.data_z;
               if (rd_q || !bus.data_z)
                  state_d = (WAIT_CYC == 0) ? ST_DATA : ST_WAITST;
            end else if (io_start && rd_q && !wr_q && !bus.address_z) begin
               do_io_rd = 1'b1;
               set_oe   = 1'b1;
               state_d  = ST_HOLD;
            end
         end
         ST_WAITST: begin
            if (!mem_req) begin
               clr_oe  = 1'b1;
               state_d = ST_IDLE;
            end else if (wcnt_q <= WCW'(1)) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (!mem_req) begin
               clr_oe  = 1'b1;
               state_d = ST_IDLE;
            end else if (!acc_rd_q) begin
               state_d = ST_HOLD;
            end else if (got_q || rdata_vld) begin
               set_oe  = 1'b1;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!(acc_io_q ? io_req : mem_req)) begin
               clr_oe  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         data_o_q    <= '0;
         data_oe_q   <= 1'b0;
         acc_rd_q    <= 1'b0;
         acc_io_q    <= 1'b0;
         got_q       <= 1'b0;
         wcnt_q      <= '0;
      end else begin
         mem_rd_q <= do_mem_rd;
         mem_wr_q <= do_mem_wr;
         if (do_mem_rd || do_mem_wr) begin
            mem_addr_q <= bus.address;
            acc_rd_q   <= do_mem_rd;
            acc_io_q   <= 1'b0;
            got_q      <= 1'b0;
            wcnt_q     <= WCW'(WAIT_CYC);
         end else if (state_q == ST_WAITST) begin
            wcnt_q <= wcnt_q - WCW'(1);
         end
         if (do_mem_wr) mem_wdata_q <= bus.data_i;
         if (do_io_rd) begin
            data_o_q <= io_read_data(bus.address[0]);
            acc_io_q <= 1'b1;
            acc_rd_q <= 1'b0;
         end else if (capture) begin
            data_o_q <= bus.mem_rdata;
            got_q    <= 1'b1;
         end
         if (set_oe)      data_oe_q <= 1'b1;
         else if (clr_oe) data_oe_q <= 1'b0;
      end
   end

   assign con_push = do_mem_wr && (bus.address == CON_ADDR);

   z80_con_fifo #(
      .DEPTH (CON_DEPTH),
      .W     (8)
   ) u_con_fifo (
      .clk      (mclk),
      .rst_n    (rst_n),
      .push     (con_push),
      .push_dat (bus.data_i),
      .pop      (bus.con_ready),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .head     (bus.con_data)
   );

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         con_ovf_q <= 1'b0;
         halted_q  <= 1'b0;
         zclocks_q <= '0;
      end else begin
         // A pop on the same edge frees the slot, so only an unpopped full FIFO loses the byte.
         if (con_push && fifo_full && !bus.con_ready) con_ovf_q <= 1'b1;
         if (halt_q) halted_q <= 1'b1;
         if (zclk_q && !zclk_qq && !halted_q && (zclocks_q != '1))
            zclocks_q <= zclocks_q + CNT_W'(1);
      end
   end

   assign bus.data_o    = data_o_q;
   assign bus.data_oe   = data_oe_q;
   assign bus.wait_n    = (state_q != ST_WAITST);
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_rd    = mem_rd_q;
   assign bus.mem_wr    = mem_wr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.con_valid = !fifo_empty;
   assign bus.con_ovf   = con_ovf_q;
   assign bus.halted    = halted_q;
   assign bus.zclocks   = zclocks_q;
endmodule
